uart_tx_fifo: RTL and testbench

- Transmit-side data buffer directly upstream of the UART TX shift register.
- Host writes bytes in; the shift register pulls them out with an active-low read strobe.
- Show-ahead (first-word-fall-through) output: the head byte is on data_o and is captured in the same cycle that n_re_i is low.
- Provides empty/full/count status plus sticky overflow/underflow error flags.

---
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding the UART TX shift register: show-ahead head word, active-low strobes.
// Define UART_TX_FIFO_ALMOST_FULL_EN to add the AF_LEVEL parameter and the p_almost_full_o output.
module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
   ,parameter int AF_LEVEL = 12
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  n_we_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  n_re_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  p_empty_o,
   output logic                  p_full_o,
   output logic [ADDR_WIDTH:0]   count_o,
   input  logic                  p_flush_i,
   input  logic                  p_err_clr_i,
   output logic                  p_overflow_o,
   output logic                  p_underflow_o
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
   ,output logic                 p_almost_full_o
`endif
);

   localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

   logic [1:0]            r_rst_sync;
   logic                  w_rst_n;
   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH:0]   r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic [ADDR_WIDTH:0]   w_count_nxt;
   logic                  r_overflow;
   logic                  r_underflow;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_wr_en;
   logic                  w_rd_en;
   logic                  w_ovf_set;
   logic                  w_unf_set;

   // Reset asserts immediately but is released only after two clean clock edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   assign w_empty = (r_rd_ptr == r_wr_ptr);
   assign w_full  = (r_rd_ptr[ADDR_WIDTH-1:0] == r_wr_ptr[ADDR_WIDTH-1:0]) &&
                    (r_rd_ptr[ADDR_WIDTH] != r_wr_ptr[ADDR_WIDTH]);

   assign w_wr_en   = !n_we_i && !w_full;
   assign w_rd_en   = !n_re_i && !w_empty;
   assign w_ovf_set = !n_we_i && w_full && !p_flush_i;
   assign w_unf_set = !n_re_i && w_empty && !p_flush_i;

   always_ff @(posedge clk) begin
      if (w_wr_en && !p_flush_i) begin
         r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= data_i;
      end
   end

   // Head word is presented combinationally so the consumer captures it on the strobe edge.
   assign data_o = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

   always_comb begin
      w_count_nxt = r_count;
      if (p_flush_i) begin
         w_count_nxt = '0;
      end else if (w_wr_en && !w_rd_en) begin
         w_count_nxt = r_count + PTR_ONE;
      end else if (!w_wr_en && w_rd_en) begin
         w_count_nxt = r_count - PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_count <= w_count_nxt;
         if (p_flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_wr_en) begin
               r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_en) begin
               r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
         end
      end
   end

   // Sticky error flags: a new error in the clearing cycle takes priority.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end else if (p_err_clr_i) begin
            r_overflow <= 1'b0;
         end
         if (w_unf_set) begin
            r_underflow <= 1'b1;
         end else if (p_err_clr_i) begin
            r_underflow <= 1'b0;
         end
      end
   end

`ifdef UART_TX_FIFO_ALMOST_FULL_EN
   localparam logic [ADDR_WIDTH:0] AF_CMP = (ADDR_WIDTH + 1)'(AF_LEVEL);

   logic r_almost_full;

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_almost_full <= 1'b0;
      end else begin
         r_almost_full <= (w_count_nxt >= AF_CMP);
      end
   end

   assign p_almost_full_o = r_almost_full;
`endif

   assign count_o       = r_count;
   assign p_empty_o     = w_empty;
   assign p_full_o      = w_full;
   assign p_overflow_o  = r_overflow;
   assign p_underflow_o = r_underflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queue-based reference model, directed cases, then random traffic.
module tb_uart_tx_fifo;

   logic       clk;
   logic       rst;
   logic       nWe;
   logic [7:0] dataIn;
   logic       nRe;
   logic [7:0] dataOut;
   logic       pEmpty;
   logic       pFull;
   logic [4:0] count;
   logic       pFlush;
   logic       pErrClr;
   logic       pOverflow;
   logic       pUnderflow;
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
   logic       pAlmostFull;
`endif

   int tests = 0;
   int fails = 0;

   logic [7:0] modelQ[$];
   logic [7:0] expQ[$];
   logic       mOvf;
   logic       mUnf;

   uart_tx_fifo dut (
      .clk           (clk),
      .rst           (rst),
      .n_we_i        (nWe),
      .data_i        (dataIn),
      .n_re_i        (nRe),
      .data_o        (dataOut),
      .p_empty_o     (pEmpty),
      .p_full_o      (pFull),
      .count_o       (count),
      .p_flush_i     (pFlush),
      .p_err_clr_i   (pErrClr),
      .p_overflow_o  (pOverflow),
      .p_underflow_o (pUnderflow)
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
      ,.p_almost_full_o (pAlmostFull)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      int sz;
      sz = modelQ.size();
      check("count", 32'(count), 32'(sz));
      check("empty", 32'(pEmpty), 32'(sz == 0));
      check("full", 32'(pFull), 32'(sz == 16));
      check("overflow", 32'(pOverflow), 32'(mOvf));
      check("underflow", 32'(pUnderflow), 32'(mUnf));
      check("data_o", 32'(dataOut), (sz > 0) ? 32'(modelQ[0]) : 32'd0);
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
      check("almost_full", 32'(pAlmostFull), 32'(sz >= 12));
`endif
   endtask

   // Drive one cycle of strobes, advance the model by the FIFO rules, then compare status.
   task automatic applyStimulus(input logic we, input logic [7:0] d, input logic re,
                                input logic fl, input logic cl);
      logic isFull;
      logic isEmpty;
      logic ovfSet;
      logic unfSet;
      nWe     = we;
      dataIn  = d;
      nRe     = re;
      pFlush  = fl;
      pErrClr = cl;
      isFull  = (modelQ.size() == 16);
      isEmpty = (modelQ.size() == 0);
      ovfSet  = 1'b0;
      unfSet  = 1'b0;
      if (fl) begin
         modelQ.delete();
      end else begin
         ovfSet = !we && isFull;
         unfSet = !re && isEmpty;
         if (!re && !isEmpty) expQ.push_back(modelQ.pop_front());
         if (!we && !isFull) modelQ.push_back(d);
      end
      mOvf = ovfSet ? 1'b1 : (cl ? 1'b0 : mOvf);
      mUnf = unfSet ? 1'b1 : (cl ? 1'b0 : mUnf);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic doReset(input bit checkNow);
      nWe     = 1'b1;
      nRe     = 1'b1;
      pFlush  = 1'b0;
      pErrClr = 1'b0;
      rst     = 1'b0;
      modelQ.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
      if (checkNow) begin
         #1;
         checkOutput();
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput();
      rst = 1'b1;
      idle(4);
   endtask

   // Consumer side: capture the head word whenever a read is actually accepted.
   always @(negedge clk) begin
      if (rst && !pFlush && !nRe && !pEmpty) begin
         if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_read: got 0x%0h, expected no read", dataOut);
         end else begin
            check("read_data", 32'(dataOut), 32'(expQ.pop_front()));
         end
      end
   end

   initial begin
      int wrProb;
      rst     = 1'b1;
      nWe     = 1'b1;
      nRe     = 1'b1;
      dataIn  = 8'h00;
      pFlush  = 1'b0;
      pErrClr = 1'b0;
      mOvf    = 1'b0;
      mUnf    = 1'b0;
      #3;
      doReset(1'b0);

      applyStimulus(1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      idle(1);

      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'(i), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'hAA, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'hEE, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'(8'h30 + i), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h77, 1'b1, 1'b1, 1'b0);
      idle(1);

      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0);
      #2;
      doReset(1'b1);

      for (int p = 0; p < 3; p++) begin
         wrProb = 75 - 25 * p;
         for (int i = 0; i < 150; i++) begin
            applyStimulus(($urandom_range(99) < wrProb) ? 1'b0 : 1'b1, 8'($urandom),
                          ($urandom_range(99) < (100 - wrProb)) ? 1'b0 : 1'b1,
                          ($urandom_range(63) == 0), ($urandom_range(7) == 0));
         end
      end
      for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      idle(2);
      check("pending_reads", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
